// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch (I) and load/store (D).
// Latency: request seen in IDLE at cycle 0 -> mem_en at cycle 1 -> ready pulse at cycle 1+MEM_LATENCY.
// Backpressure: one access in flight; losers see stall_if/stall_mem until their ready pulse.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  // Last WAIT count value; unreachable when MEM_LATENCY == 1 because WAIT is skipped.
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            own_d_q, own_d_d;      // 1 = D side owns the memory, 0 = I side
  logic [SCW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            grant_i;

  // Next-state logic: arbitration in IDLE, then sequence the single outstanding access.
  always_comb begin
    state_d      = state_q;
    own_d_d      = own_d_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    grant_i      = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          // D wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
          grant_i  = i_req && (!d_req || (starve_cnt_q == STARVE_MAX));
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          own_d_d  = !grant_i;
          if (grant_i) begin
            mem_addr_d   = i_addr;
            mem_we_d     = 1'b0;
            mem_wdata_d  = 32'h0;
            mem_be_d     = 4'hF;
            starve_cnt_d = '0;
          end else begin
            mem_addr_d   = d_addr;
            mem_we_d     = d_we;
            mem_wdata_d  = d_wdata;
            mem_be_d     = d_we ? d_be : 4'hF;
            if (!i_req) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
              starve_cnt_d = starve_cnt_q + SCW'(1);
            end
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      ISSUE: begin
        if (MEM_LATENCY == 1) begin
          state_d   = RESP;
          i_ready_d = !own_d_q;
          d_ready_d = own_d_q;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d   = RESP;
          i_ready_d = !own_d_q;
          d_ready_d = own_d_q;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered memory/ready outputs; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      own_d_q      <= 1'b0;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'h0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_d_q      <= own_d_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  // Read data arrives from memory in the RESP cycle itself, so it is passed through.
  assign i_rdata   = i_ready_q ? mem_rdata : 32'h0;
  assign d_rdata   = (d_ready_q && !mem_we_q) ? mem_rdata : 32'h0;
  assign stall_if  = i_req && !i_ready_q;
  assign stall_mem = d_req && !d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: instance A (latency 2, starve limit 4), instance B (latency 1).
// Table-driven single transactions plus hand sequences for reset, arbitration, starvation.
// Memory models return data exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_i_req = 0, a_d_req = 0, a_d_we = 0;
  logic [31:0] a_i_addr = 0, a_d_addr = 0, a_d_wdata = 0;
  logic [3:0]  a_d_be = 0;
  logic        a_i_ready, a_d_ready, a_stall_if, a_stall_mem, a_mem_en, a_mem_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;

  logic        b_i_req = 0, b_d_req = 0, b_d_we = 0;
  logic [31:0] b_i_addr = 0, b_d_addr = 0, b_d_wdata = 0;
  logic [3:0]  b_d_be = 0;
  logic        b_i_ready, b_d_ready, b_stall_if, b_stall_mem, b_mem_en, b_mem_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_be(a_d_be),
    .d_ready(a_d_ready), .d_rdata(a_d_rdata),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_be(b_d_be),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
  );

  // Memory model A: 64 words, byte-enabled writes, read data valid 2 cycles after mem_en.
  logic [31:0] mem_a [64];
  logic        a_v1, a_v2;
  logic [31:0] a_a1, a_a2;
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mem_a[k] <= (k == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(k);
      a_v1 <= 1'b0;
      a_v2 <= 1'b0;
    end else begin
      a_v1 <= a_mem_en & ~a_mem_we;
      a_a1 <= a_mem_addr;
      a_v2 <= a_v1;
      a_a2 <= a_a1;
      if (a_mem_en && a_mem_we)
        for (int k = 0; k < 4; k++)
          if (a_mem_be[k]) mem_a[a_mem_addr[7:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end
  end
  assign a_mem_rdata = a_v2 ? mem_a[a_a2[7:2]] : 32'hBAD0_BAD0;

  // Memory model B: read-only, data valid 1 cycle after mem_en.
  logic        b_v1;
  logic [31:0] b_a1;
  always @(posedge clk) begin
    if (rst) b_v1 <= 1'b0;
    else begin
      b_v1 <= b_mem_en;
      b_a1 <= b_mem_addr;
    end
  end
  assign b_mem_rdata = b_v1 ? (32'h1000_0000 + {26'b0, b_a1[7:2]}) : 32'hBAD0_BAD0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        exp_d;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Single transactions on instance A, each started from IDLE.
    vecs[0] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40,  32'h12345678, 4'h3, 1'b1, 1'b1, 32'h40,  32'h12345678, 4'h3, 32'h0};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 1'b1, 1'b0, 32'h40,  32'h0,        4'hF, 32'h10005678};
    vecs[3] = '{1'b1, 32'h8,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h8,   32'h0,        4'hF, 32'h10000002};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h44,  32'hAABBCCDD, 4'hC, 1'b1, 1'b1, 32'h44,  32'hAABBCCDD, 4'hC, 32'h0};
    vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h44,  32'h0,        4'hF, 32'hAABB0011};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'hFC,  32'h0,        4'h0, 1'b1, 1'b0, 32'hFC,  32'h0,        4'hF, 32'h1000003F};

    // Reset state.
    repeat (3) tick;
    @(negedge clk);
    chk("rst a mem_en",    32'(a_mem_en),   32'h0);
    chk("rst a mem_we",    32'(a_mem_we),   32'h0);
    chk("rst a mem_addr",  a_mem_addr,      32'h0);
    chk("rst a mem_wdata", a_mem_wdata,     32'h0);
    chk("rst a mem_be",    32'(a_mem_be),   32'h0);
    chk("rst a i_ready",   32'(a_i_ready),  32'h0);
    chk("rst a d_ready",   32'(a_d_ready),  32'h0);
    chk("rst b mem_en",    32'(b_mem_en),   32'h0);
    chk("rst b i_ready",   32'(b_i_ready),  32'h0);
    tick;
    rst = 1'b0;
    tick;

    // Table-driven single transactions.
    for (int v = 0; v < 7; v++) begin
      a_i_req   = vecs[v].ireq;
      a_i_addr  = vecs[v].iaddr;
      a_d_req   = vecs[v].dreq;
      a_d_we    = vecs[v].dwe;
      a_d_addr  = vecs[v].daddr;
      a_d_wdata = vecs[v].dwdata;
      a_d_be    = vecs[v].dbe;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d c%0d mem_en", v, c), 32'(a_mem_en), 32'(c == 1));
        chk($sformatf("v%0d c%0d d_ready", v, c), 32'(a_d_ready), 32'(vecs[v].exp_d && c == 3));
        chk($sformatf("v%0d c%0d i_ready", v, c), 32'(a_i_ready), 32'(!vecs[v].exp_d && c == 3));
        chk($sformatf("v%0d c%0d stall", v, c),
            32'(vecs[v].exp_d ? a_stall_mem : a_stall_if), 32'(c != 3));
        if (c == 1) begin
          chk($sformatf("v%0d mem_addr", v), a_mem_addr, vecs[v].exp_addr);
          chk($sformatf("v%0d mem_we", v), 32'(a_mem_we), 32'(vecs[v].exp_we));
          chk($sformatf("v%0d mem_be", v), 32'(a_mem_be), 32'(vecs[v].exp_be));
          if (vecs[v].exp_we) chk($sformatf("v%0d mem_wdata", v), a_mem_wdata, vecs[v].exp_wdata);
        end
        if (c == 3)
          chk($sformatf("v%0d rdata", v), vecs[v].exp_d ? a_d_rdata : a_i_rdata, vecs[v].exp_rdata);
        tick;
      end
      a_i_req = 1'b0;
      a_d_req = 1'b0;
    end

    // Request dropped mid-flight: access still completes with a ready pulse.
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h8;
    tick;
    a_d_req = 1'b0;
    @(negedge clk); chk("viol mem_en c1", 32'(a_mem_en), 32'h1);
    tick;
    @(negedge clk); chk("viol stall_mem c2", 32'(a_stall_mem), 32'h0);
    tick;
    @(negedge clk);
    chk("viol d_ready c3", 32'(a_d_ready), 32'h1);
    chk("viol d_rdata c3", a_d_rdata, 32'h10000002);
    tick;
    @(negedge clk);
    chk("viol mem_en c4", 32'(a_mem_en), 32'h0);
    chk("viol d_ready c4", 32'(a_d_ready), 32'h0);
    tick;

    // Reset during WAIT: access dropped, no ready pulse, outputs cleared.
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    tick;
    tick;
    rst = 1'b1; a_d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (c == 1) rst = 1'b0;
      @(negedge clk);
      chk($sformatf("mrst %0d d_ready", c), 32'(a_d_ready), 32'h0);
      chk($sformatf("mrst %0d mem_en", c), 32'(a_mem_en), 32'h0);
      chk($sformatf("mrst %0d mem_addr", c), a_mem_addr, 32'h0);
      chk($sformatf("mrst %0d mem_be", c), 32'(a_mem_be), 32'h0);
    end
    tick;

    // Simultaneous requests: D first, then I.
    a_i_req = 1'b1; a_i_addr = 32'h8;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("both c%0d mem_en", c), 32'(a_mem_en), 32'(c == 1 || c == 5));
      chk($sformatf("both c%0d d_ready", c), 32'(a_d_ready), 32'(c == 3));
      chk($sformatf("both c%0d i_ready", c), 32'(a_i_ready), 32'(c == 7));
      chk($sformatf("both c%0d stall_if", c), 32'(a_stall_if), 32'(c < 7));
      chk($sformatf("both c%0d stall_mem", c), 32'(a_stall_mem), 32'(c < 3));
      if (c == 3) chk("both d_rdata", a_d_rdata, 32'hDEADBEEF);
      if (c == 5) chk("both i mem_addr", a_mem_addr, 32'h8);
      if (c == 7) chk("both i_rdata", a_i_rdata, 32'h10000002);
      tick;
      if (c == 3) a_d_req = 1'b0;
      if (c == 7) a_i_req = 1'b0;
    end

    // Starvation: D held continuously, I pending -> D D D D I D.
    begin
      int          n, last, cyc;
      logic        drop_i;
      logic [31:0] iss [6];
      n = 0; last = 0; cyc = 0;
      a_i_req = 1'b1; a_i_addr = 32'h8;
      a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
      while (n < 6 && cyc < 60) begin
        @(negedge clk);
        if (a_mem_en) begin
          iss[n] = a_mem_addr;
          if (n > 0) chk($sformatf("starve gap %0d", n), 32'(cyc - last), 32'd4);
          if (n == 3) chk("starve cnt at 4th D", 32'(dut_a.starve_cnt_q), 32'd4);
          if (n == 4) chk("starve cnt after I", 32'(dut_a.starve_cnt_q), 32'd0);
          last = cyc;
          n++;
        end
        drop_i = a_i_ready;
        tick;
        if (drop_i) a_i_req = 1'b0;
        cyc++;
      end
      if (n < 6) begin
        total++;
        bad++;
        $display("FAIL starve timeout: got %0d issues want 6", n);
      end
      for (int k = 0; k < n; k++)
        chk($sformatf("starve issue %0d", k), iss[k], (k == 4) ? 32'h8 : 32'h100);
      a_d_req = 1'b0;
      a_i_req = 1'b0;
      repeat (5) tick;
    end

    // MEM_LATENCY=1: fetch held for two back-to-back accesses.
    b_i_req = 1'b1; b_i_addr = 32'h8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("l1 c%0d mem_en", c), 32'(b_mem_en), 32'(c == 1 || c == 4));
      chk($sformatf("l1 c%0d i_ready", c), 32'(b_i_ready), 32'(c == 2 || c == 5));
      chk($sformatf("l1 c%0d stall_if", c), 32'(b_stall_if), 32'(c != 2 && c != 5));
      chk($sformatf("l1 c%0d d_ready", c), 32'(b_d_ready), 32'h0);
      if (c == 1) begin
        chk("l1 mem_be", 32'(b_mem_be), 32'hF);
        chk("l1 mem_we", 32'(b_mem_we), 32'h0);
        chk("l1 mem_addr", b_mem_addr, 32'h8);
      end
      if (c == 2 || c == 5) chk($sformatf("l1 c%0d i_rdata", c), b_i_rdata, 32'h10000002);
      tick;
    end
    b_i_req = 1'b0;
    repeat (3) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
